uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UartTransmitter between NUM_REQ byte producers (console, status, debug...).
//  Round-robin grant; drives the transmitter's din/wr_en and tracks its tx_busy to sequence one byte at a time.
//  Sits in system_clk domain between the producers and the UART TX datapath.
// PARAMETERS
//  NUM_REQ        4     number of requesters (2..8)
//  DATA_W         8     byte width (must match transmitter din)
//  START_TIMEOUT  4096  system_clk cycles to wait for tx_busy rise after wr_en before abort
// PORTS
//  system_clk   in   1              single clock, all logic rising-edge
//  reset        in   1              synchronous, active-high
//  req_valid    in   NUM_REQ        per-requester byte available; held until matching req_ready
//  req_data     in   NUM_REQ*DATA_W requester i byte at [i*DATA_W +: DATA_W]; stable while req_valid
//  req_ready    out  NUM_REQ        one-cycle pulse: byte of requester i accepted by transmitter
//  tx_din       out  DATA_W         byte to transmitter; registered, stable for whole transfer
//  tx_wr_en     out  1              one-cycle start pulse to transmitter
//  tx_busy      in   1              transmitter busy (clken-domain flop); double-synchronised here
//  grant_id     out  $clog2(NUM_REQ) index of current/last granted requester
//  active       out  1              high whenever FSM != IDLE
//  err_timeout  out  1              one-cycle pulse: tx_busy never rose within START_TIMEOUT
// BEHAVIOUR
//  Reset: FSM=IDLE, tx_wr_en=0, req_ready=0, err_timeout=0, tx_din=0, grant_id=0, rr pointer=0, sync flops=0.
//  busy_s = tx_busy through 2 system_clk flops (2-cycle latency); all FSM decisions use busy_s.
//  FSM:
//   IDLE:      if any req_valid & !busy_s -> pick winner, latch tx_din=req_data[w], grant_id=w -> ISSUE.
//   ISSUE:     tx_wr_en=1 for exactly this cycle; clear timeout counter -> WAIT_START.
//   WAIT_START:busy_s=1 -> req_ready[grant_id] pulse next cycle, -> WAIT_DONE.
//              counter==START_TIMEOUT-1 -> err_timeout pulse, no req_ready, -> IDLE (requester re-arbitrated).
//   WAIT_DONE: busy_s=0 -> rr pointer = grant_id+1 (mod NUM_REQ) -> IDLE.
//  Round robin: search order starts at rr pointer, wraps at NUM_REQ-1 -> 0; first set req_valid wins.
//   Pointer advances only on completed transfer (not on timeout).
//  req_ready: at most one bit set, only for grant_id, exactly one pulse per accepted byte.
//  Min IDLE->IDLE latency: 3 (IDLE,ISSUE,WAIT_START) + sync delay + frame time; back-to-back grant allowed
//   in the IDLE cycle following WAIT_DONE.
//  Requester drops req_valid after grant: ignored, byte already latched and still sent (protocol violation,
//   bench flags it). Requester changes req_data while valid: unsupported.
//  busy_s already high in IDLE (transmitter owned elsewhere / leftover): no grant until it falls.
//  Timeout counter saturating, width $clog2(START_TIMEOUT+1); never wraps.
//  reset mid-transfer: immediate return to reset state; in-flight UART frame is not tracked or acknowledged.
//  No default-state lockup: illegal FSM encoding -> IDLE.
// STRUCTURE
//  Shared package uart_pkg: FSM state localparams (IDLE/ISSUE/WAIT_START/WAIT_DONE), UART_DATA_W=8.
//  One sub-module: rr_pick (combinational): inputs req vector + pointer, outputs winner index + any_valid.
//  Synchroniser and timeout counter inline.
// TESTING
//  1 single req: req_valid[2]=1, data 8'hA5 -> one tx_wr_en pulse, tx_din=A5, req_ready[2] after busy rise.
//  2 all 4 valid continuously from reset -> grant order 0,1,2,3,0; one req_ready per byte, no gaps >1 IDLE cycle.
//  3 req1 and req3 valid, pointer=2 -> req3 wins first, then req1; pointer ends at 2.
//  4 tx_busy tied 0 -> err_timeout pulse after START_TIMEOUT cycles, no req_ready, re-issue same requester.
//  5 reset asserted in WAIT_DONE -> next cycle all outputs at reset values, grant_id=0, active=0.
//  6 tx_busy held high in IDLE with req_valid[0]=1 -> no tx_wr_en until busy falls + 2-cycle sync.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART-side definitions: transmitter byte width, arbiter FSM states
// and the round-robin index wrap helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_t;

  // Wraps idx back into 0..n-1; callers never pass idx >= 2*n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// searching upwards and wrapping from N-1 back to 0.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          any_valid
);

  logic [PW-1:0] idx_s;

  // Walk the search order backwards so the candidate closest to ptr is written last.
  always_comb begin
    winner    = '0;
    any_valid = |req;
    idx_s     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s  = PW'(rr_wrap(int'(ptr) + k, N));
      winner = req[idx_s] ? idx_s : winner;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// producers; issues one byte at a time and follows the transmitter's tx_busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = UART_DATA_W,
  parameter int START_TIMEOUT = 4096
) (
  input  logic                       system_clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_din,
  output logic                       tx_wr_en,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  arb_state_t         state_r, state_nx_s;
  logic               busy_m_r, busy_s_r;
  logic [PTR_W-1:0]   rr_ptr_r, win_s, grant_id_r;
  logic               any_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               start_s, accept_s, timeout_s, done_s;
  logic [NUM_REQ-1:0] req_ready_r;
  logic [DATA_W-1:0]  tx_din_r;
  logic               tx_wr_en_r, active_r, err_timeout_r;

  rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .winner    (win_s),
    .any_valid (any_s)
  );

  // Two-flop synchroniser for the transmitter's busy flag.
  always_ff @(posedge system_clk) begin
    if (reset) begin
      busy_m_r <= 1'b0;
      busy_s_r <= 1'b0;
    end else begin
      busy_m_r <= tx_busy;
      busy_s_r <= busy_m_r;
    end
  end

  // Next-state decode and single-cycle event strobes.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    accept_s   = 1'b0;
    timeout_s  = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A busy transmitter here is owned elsewhere; wait for it to drop.
        if (any_s && !busy_s_r) begin
          start_s    = 1'b1;
          state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nx_s = ST_WAIT_START;
      ST_WAIT_START: begin
        if (busy_s_r) begin
          accept_s   = 1'b1;
          state_nx_s = ST_WAIT_DONE;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT_START;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_s_r) begin
          done_s     = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, registered outputs, round-robin pointer and start timeout counter.
  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      active_r      <= 1'b0;
      tx_wr_en_r    <= 1'b0;
      err_timeout_r <= 1'b0;
      req_ready_r   <= '0;
      tx_din_r      <= '0;
      grant_id_r    <= '0;
      rr_ptr_r      <= '0;
      cnt_r         <= '0;
    end else begin
      state_r       <= state_nx_s;
      active_r      <= (state_nx_s != ST_IDLE);
      tx_wr_en_r    <= start_s;
      err_timeout_r <= timeout_s;
      req_ready_r   <= accept_s ? (NUM_REQ'(1) << grant_id_r) : '0;
      if (start_s) begin
        tx_din_r   <= req_data[win_s*DATA_W +: DATA_W];
        grant_id_r <= win_s;
      end
      // Only a completed frame moves the pointer; a timed-out requester keeps priority.
      if (done_s) begin
        rr_ptr_r <= PTR_W'(rr_wrap(int'(grant_id_r) + 1, NUM_REQ));
      end
      if (state_r == ST_ISSUE) begin
        cnt_r <= '0;
      end else if (state_r == ST_WAIT_START && cnt_r != '1) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign tx_din      = tx_din_r;
  assign tx_wr_en    = tx_wr_en_r;
  assign grant_id    = grant_id_r;
  assign active      = active_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: a behavioural transmitter drives
// tx_busy and a transaction-level model predicts every output cycle by cycle.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 32;

  logic         system_clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0] req_ready;
  logic [7:0]   tx_din;
  logic         tx_wr_en;
  logic         tx_busy;
  logic [1:0]   grant_id;
  logic         active;
  logic         err_timeout;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(8), .START_TIMEOUT(TO)) dut (
    .system_clk  (system_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_din      (tx_din),
    .tx_wr_en    (tx_wr_en),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .err_timeout (err_timeout)
  );

  always #5 system_clk = ~system_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] data_q [N];
  int win_log [$];

  // Model state: the first cycle the arbiter is idle again, pointer, pending events.
  int free_from = 1 << 30;
  int m_ptr = 0, cur_win = 0;
  int exp_ready_at = -1, exp_err_at = -1, rise_at = -1, fall_at = -1;
  int dead_pct = 0, rate = 0;
  bit model_on = 1'b0, gen_on = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) req_data[i*8 +: 8] = data_q[i];
  endtask

  function automatic int pick(input int ptr);
    for (int k = 0; k < N; k++)
      if (req_valid[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_check();
    logic exp_wr;
    int win, l, f;
    // A decision made in an idle cycle shows up as tx_wr_en one cycle later.
    exp_wr = (cyc - 1 >= free_from) && (req_valid != '0);
    check_eq("wr_en", tx_wr_en, exp_wr);
    if (exp_wr) begin
      win = pick(m_ptr);
      win_log.push_back(win);
      check_eq("grant_id", grant_id, win);
      check_eq("tx_din", tx_din, data_q[win]);
      cur_win = win;
      if ($urandom_range(1, 100) <= dead_pct) begin
        exp_err_at = cyc + TO + 1;
        free_from  = exp_err_at;
      end else begin
        l = $urandom_range(1, 4);
        f = $urandom_range(2, 8);
        rise_at      = cyc + l;
        fall_at      = cyc + l + f;
        exp_ready_at = cyc + l + 3;
        free_from    = cyc + l + f + 3;
        m_ptr        = (win + 1) % N;
      end
    end
    check_eq("active", active, cyc < free_from);
    check_eq("req_ready", req_ready, (cyc == exp_ready_at) ? (4'b0001 << cur_win) : 4'b0000);
    check_eq("err_timeout", err_timeout, cyc == exp_err_at);
  endtask

  task automatic step();
    @(negedge system_clk);
    cyc++;
    if (model_on) model_check();
    for (int i = 0; i < N; i++) if (req_ready[i]) req_valid[i] = 1'b0;
    if (cyc == rise_at) tx_busy = 1'b1;
    if (cyc == fall_at) tx_busy = 1'b0;
    if (gen_on)
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(1, 100) <= rate) begin
          req_valid[i] = 1'b1;
          data_q[i]    = 8'($urandom);
        end
    pack();
  endtask

  task automatic do_reset();
    model_on = 1'b0; gen_on = 1'b0; reset = 1'b1; tx_busy = 1'b0; req_valid = '0;
    rise_at = -1; fall_at = -1; exp_ready_at = -1; exp_err_at = -1;
    pack();
    step();
    check_eq("rst_wr_en", tx_wr_en, 32'd0);
    check_eq("rst_req_ready", req_ready, 32'd0);
    check_eq("rst_err", err_timeout, 32'd0);
    check_eq("rst_tx_din", tx_din, 32'd0);
    check_eq("rst_grant_id", grant_id, 32'd0);
    check_eq("rst_active", active, 32'd0);
    step();
    reset = 1'b0; free_from = cyc; m_ptr = 0; model_on = 1'b1;
    win_log.delete();
  endtask

  initial begin
    int n_rdy, n_err, n_wr;
    bit seen;
    for (int i = 0; i < N; i++) data_q[i] = 8'h00;

    // 1: single requester 2 with byte A5
    do_reset();
    req_valid[2] = 1'b1; data_q[2] = 8'hA5; pack();
    n_rdy = 0;
    repeat (40) begin step(); if (req_ready[2]) n_rdy++; end
    check_eq("t1_ready_count", n_rdy, 1);
    check_eq("t1_grants", win_log.size(), 1);

    // 2: all requesters continuously valid
    do_reset();
    gen_on = 1'b1; rate = 100;
    repeat (200) begin step(); if (win_log.size() >= 5) break; end
    check_eq("t2_grants", win_log.size() >= 5, 1);
    if (win_log.size() >= 5)
      for (int i = 0; i < 5; i++) check_eq("t2_order", win_log[i], i % N);

    // 3: pointer at 2 with requesters 1 and 3 pending
    do_reset();
    req_valid[1] = 1'b1; data_q[1] = 8'h11; pack();
    seen = 1'b0;
    repeat (60) begin step(); if (req_ready[1]) begin seen = 1'b1; break; end end
    check_eq("t3_first_ready", seen, 1);
    req_valid[1] = 1'b1; req_valid[3] = 1'b1; data_q[1] = 8'h22; data_q[3] = 8'h33; pack();
    repeat (100) begin step(); if (win_log.size() >= 3) break; end
    seen = 1'b0;
    repeat (60) begin step(); if (req_ready != '0) begin seen = 1'b1; break; end end
    check_eq("t3_second_ready", seen, 1);
    req_valid = '1; pack();
    repeat (100) begin step(); if (win_log.size() >= 4) break; end
    check_eq("t3_grants", win_log.size(), 4);
    if (win_log.size() >= 4) begin
      check_eq("t3_win_a", win_log[1], 3);
      check_eq("t3_win_b", win_log[2], 1);
      check_eq("t3_ptr_after", win_log[3], 2);
    end

    // 4: transmitter never answers
    do_reset();
    dead_pct = 100;
    req_valid[1] = 1'b1; data_q[1] = 8'h5A; pack();
    n_rdy = 0; n_err = 0;
    repeat (2 * (TO + 2) + 4) begin
      step();
      if (req_ready != '0) n_rdy++;
      if (err_timeout) n_err++;
    end
    check_eq("t4_err_count", n_err, 2);
    check_eq("t4_ready_count", n_rdy, 0);
    check_eq("t4_reissue", (win_log.size() >= 2) && (win_log[0] == 1) && (win_log[1] == 1), 1);
    dead_pct = 0;

    // Random traffic with occasional dead transmitter
    do_reset();
    gen_on = 1'b1; rate = 20; dead_pct = 10;
    repeat (1500) step();

    // 5: reset while waiting for the frame to finish
    dead_pct = 0;
    seen = 1'b0;
    repeat (400) begin step(); if (req_ready != '0) begin seen = 1'b1; break; end end
    check_eq("t5_in_wait_done", seen, 1);
    do_reset();

    // 6: transmitter busy from elsewhere while requester 0 waits
    model_on = 1'b0;
    tx_busy = 1'b1;
    repeat (3) step();
    req_valid[0] = 1'b1; data_q[0] = 8'h3C; pack();
    n_wr = 0;
    repeat (10) begin step(); if (tx_wr_en) n_wr++; end
    check_eq("t6_no_wr_busy", n_wr, 0);
    tx_busy = 1'b0;
    step(); check_eq("t6_sync1", tx_wr_en, 0);
    step(); check_eq("t6_sync2", tx_wr_en, 0);
    step(); check_eq("t6_wr", tx_wr_en, 1);
    check_eq("t6_grant", grant_id, 0);
    check_eq("t6_din", tx_din, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
